mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr_picker.sv | 27 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester memory port arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin winner selection; search starts just after last_winner.
module rr_picker
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_winner,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;

  // k = N_REQ wraps back to last_winner itself, so it is tried last.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = last_winner + SEL_W'(k);
      if (!valid && req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for a shared memory port: IDLE/GRANT FSM, registered grant/select.
// Optional forced release after TIMEOUT_CYCLES grant cycles when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  if (64'(TIMEOUT_CYCLES) >= (64'd1 << TIMEOUT_W)) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be less than 2**TIMEOUT_W");
  end

  arb_state_t       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_busy;
  logic [SEL_W-1:0] r_last;

  logic             w_valid;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_base;
  logic             w_to_hit;
  logic             w_release;

  // At release the new last_winner is the current sel, so search from it directly.
  assign w_base = (r_state == GRANT) ? r_sel : r_last;

  rr_picker u_picker (
    .req         (req),
    .last_winner (w_base),
    .valid       (w_valid),
    .idx         (w_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_timeout;

  // Counter value c marks the (c+1)th grant cycle; done wins over a coinciding timeout.
  assign w_to_hit = (r_state == GRANT) && !done &&
                    (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign timeout  = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      if (r_state == IDLE || w_release) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + TIMEOUT_W'(1);
      end
    end
  end
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign w_release = (r_state == GRANT) && (done || w_to_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_last  <= '1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= GRANT;
            r_gnt   <= onehot(w_idx);
            r_sel   <= w_idx;
            r_busy  <= 1'b1;
          end else begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_last <= r_sel;
            if (w_valid) begin
              r_gnt <= onehot(w_idx);
              r_sel <= w_idx;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus multi-cycle corner sequences.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_W      (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] eg, input logic [1:0] es,
                         input logic eb, input logic et);
    chk({name, ".gnt"},     32'(gnt),     32'(eg));
    chk({name, ".sel"},     32'(sel),     32'(es));
    chk({name, ".busy"},    32'(busy),    32'(eb));
    chk({name, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic d);
    @(negedge clk);
    rst_n = r;
    req   = q;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic d, input logic [3:0] g,
                     input logic [1:0] s, input logic b, input string n);
    vec_t v;
    v.rst_n = r; v.req = q; v.done = d;
    v.gnt = g; v.sel = s; v.busy = b; v.to = 1'b0; v.name = n;
    vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    if ((gnt & (gnt - 4'd1)) != 4'd0) begin
      n_bad++;
      $display("FAIL gnt_onehot: got %b, expected at most one bit", gnt);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;

    add(0, 4'b0000, 0, 4'b0000, 2'd0, 0, "reset");
    add(1, 4'b0000, 1, 4'b0000, 2'd0, 0, "done_in_idle");
    add(1, 4'b0110, 0, 4'b0010, 2'd1, 1, "first_grant");
    add(1, 4'b0000, 0, 4'b0010, 2'd1, 1, "hold_req_drop");
    add(1, 4'b1001, 0, 4'b0010, 2'd1, 1, "hold_req_change");
    add(1, 4'b1001, 1, 4'b1000, 2'd3, 1, "release_next");
    add(1, 4'b0000, 1, 4'b0000, 2'd3, 0, "release_idle");
    add(1, 4'b0000, 0, 4'b0000, 2'd3, 0, "idle_sel_keep");
    add(1, 4'b1001, 0, 4'b0001, 2'd0, 1, "wrap_order");
    add(1, 4'b0001, 1, 4'b0001, 2'd0, 1, "self_regrant");
    add(0, 4'b0000, 0, 4'b0000, 2'd0, 0, "reset2");
    add(1, 4'b1111, 0, 4'b0001, 2'd0, 1, "rr_0");
    add(1, 4'b1111, 1, 4'b0010, 2'd1, 1, "rr_1");
    add(1, 4'b1111, 1, 4'b0100, 2'd2, 1, "rr_2");
    add(1, 4'b1111, 1, 4'b1000, 2'd3, 1, "rr_3");
    add(1, 4'b1111, 1, 4'b0001, 2'd0, 1, "rr_wrap0");
    add(1, 4'b0000, 1, 4'b0000, 2'd0, 0, "rr_end");

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      chk_all(vecs[i].name, vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].to);
    end

    // Granted requester 2 drops req; grant must persist with no done.
    step(0, 4'b0000, 0);
    step(1, 4'b0100, 0);
    chk_all("req2_grant", 4'b0100, 2'd2, 1, 0);
`ifdef ARB_TIMEOUT_EN
    step(1, 4'b0000, 0);
    chk_all("to_c1", 4'b0100, 2'd2, 1, 0);
    step(1, 4'b0000, 0);
    chk_all("to_c2", 4'b0100, 2'd2, 1, 0);
    step(1, 4'b0000, 0);
    chk_all("to_c3", 4'b0100, 2'd2, 1, 0);
    step(1, 4'b0000, 0);
    chk_all("to_fire", 4'b0000, 2'd2, 0, 1);
    step(1, 4'b0000, 0);
    chk_all("to_pulse_end", 4'b0000, 2'd2, 0, 0);
    // done on the same edge the timeout would fire: counted as done.
    step(1, 4'b0001, 0);
    chk_all("coinc_grant", 4'b0001, 2'd0, 1, 0);
    step(1, 4'b0000, 0);
    step(1, 4'b0000, 0);
    step(1, 4'b0000, 0);
    chk_all("coinc_c3", 4'b0001, 2'd0, 1, 0);
    step(1, 4'b0000, 1);
    chk_all("coinc_done", 4'b0000, 2'd0, 0, 0);
`else
    for (int i = 0; i < 10; i++) begin
      step(1, 4'b0000, 0);
      chk_all($sformatf("hold10_%0d", i), 4'b0100, 2'd2, 1, 0);
    end
    step(1, 4'b0000, 1);
    chk_all("hold10_done", 4'b0000, 2'd2, 0, 0);
`endif

    // Asynchronous reset mid-grant with sel=3, then requester 0 has top priority.
    step(1, 4'b1000, 0);
    chk_all("pre_rst_grant3", 4'b1000, 2'd3, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 2'd0, 0, 0);
    step(1, 4'b1001, 0);
    chk_all("post_rst_pri0", 4'b0001, 2'd0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
